// File: rtl/ctrl_decode_pipe.sv
// RV32I(+M) decode into a registered ID/EX control bundle, 1-cycle latency when unstalled.
// Backpressure: combinational stall holds PC and IF/ID on load-use or while a divide occupies EX.
module ctrl_decode_pipe #(
    parameter int M_EXT   = 0,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_id_inst,
    input  logic        if_id_valid,
    input  logic        flush,
    output logic        stall,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_memread,
    output logic        ex_alusrc,
    output logic        ex_branch,
    output logic        ex_jal,
    output logic        ex_jalr,
    output logic        ex_auipc,
    output logic        ex_lui,
    output logic        ex_muldiv,
    output logic        ex_illegal,
    output logic [1:0]  ex_resultsrc,
    output logic [2:0]  ex_immtype,
    output logic [4:0]  ex_alucontrol,
    output logic [2:0]  ex_funct3,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2
);
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       auipc;
        logic       lui;
        logic       muldiv;
        logic       illegal;
        logic [1:0] resultsrc;
        logic [2:0] immtype;
        logic [4:0] alucontrol;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
    localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b10000, A_AND = 5'b00001, A_OR = 5'b00010,
                           A_XOR = 5'b00011, A_SLL = 5'b00100, A_SRL = 5'b00101, A_SRA = 5'b00110,
                           A_SLT = 5'b10111, A_SLTU = 5'b11000;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
    localparam logic [6:0] F7_0 = 7'b0000000, F7_ALT = 7'b0100000, F7_M = 7'b0000001;
    localparam logic [4:0] DIV_INIT = 5'(DIV_LAT - 1);

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    ctrl_t      dec, ex_d, ex_q;
    logic       use_rs1, use_rs2, load_use, busy, is_div;
    logic [4:0] cnt_d, cnt_q;

    assign opcode = if_id_inst[6:0];
    assign f3     = if_id_inst[14:12];
    assign f7     = if_id_inst[31:25];

    always_comb begin
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.funct3 = f3;
        dec.rd     = if_id_inst[11:7];
        dec.rs1    = if_id_inst[19:15];
        dec.rs2    = if_id_inst[24:20];
        case (opcode)
            OP_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.regwrite = 1'b1;
                if (f7 == F7_0) begin
                    case (f3)
                        3'b000:  dec.alucontrol = A_ADD;
                        3'b001:  dec.alucontrol = A_SLL;
                        3'b010:  dec.alucontrol = A_SLT;
                        3'b011:  dec.alucontrol = A_SLTU;
                        3'b100:  dec.alucontrol = A_XOR;
                        3'b101:  dec.alucontrol = A_SRL;
                        3'b110:  dec.alucontrol = A_OR;
                        default: dec.alucontrol = A_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec.alucontrol = A_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec.alucontrol = A_SRA;
                end else if (f7 == F7_M && M_EXT != 0) begin
                    dec.muldiv     = 1'b1;
                    dec.alucontrol = {2'b01, f3};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                use_rs1 = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.immtype = IMM_I;
                case (f3)
                    3'b000:  dec.alucontrol = A_ADD;
                    3'b010:  dec.alucontrol = A_SLT;
                    3'b011:  dec.alucontrol = A_SLTU;
                    3'b100:  dec.alucontrol = A_XOR;
                    3'b110:  dec.alucontrol = A_OR;
                    3'b111:  dec.alucontrol = A_AND;
                    3'b001: begin
                        dec.alucontrol = A_SLL;
                        dec.illegal    = (f7 != F7_0);
                    end
                    default: begin
                        dec.alucontrol = (f7 == F7_ALT) ? A_SRA : A_SRL;
                        dec.illegal    = (f7 != F7_0) && (f7 != F7_ALT);
                    end
                endcase
            end
            OP_LOAD: begin
                use_rs1 = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1; dec.alusrc = 1'b1;
                dec.resultsrc = 2'b01; dec.immtype = IMM_I;
                dec.illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.memwrite = 1'b1; dec.alusrc = 1'b1;
                dec.immtype = IMM_S;
                dec.illegal = f3[2] || (f3 == 3'b011);
            end
            OP_BR: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.branch = 1'b1; dec.immtype = IMM_B;
                dec.alucontrol = A_SUB;
                dec.illegal    = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_JAL: begin
                dec.regwrite = 1'b1; dec.jal = 1'b1; dec.resultsrc = 2'b10; dec.immtype = IMM_J;
            end
            OP_JALR: begin
                use_rs1 = 1'b1; dec.regwrite = 1'b1; dec.jalr = 1'b1; dec.alusrc = 1'b1;
                dec.resultsrc = 2'b10; dec.immtype = IMM_I;
                dec.illegal   = (f3 != 3'b000);
            end
            OP_LUI: begin
                dec.regwrite = 1'b1; dec.lui = 1'b1; dec.alusrc = 1'b1; dec.immtype = IMM_U;
            end
            OP_AUIPC: begin
                dec.regwrite = 1'b1; dec.auipc = 1'b1; dec.alusrc = 1'b1; dec.immtype = IMM_U;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal op must not write, access memory, redirect, or create a hazard.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
        dec.valid = 1'b1;
        if (!if_id_valid) begin
            dec     = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    assign is_div   = dec.muldiv && f3[2];
    assign busy     = (cnt_q != 5'd0);
    assign load_use = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                      ((use_rs1 && (dec.rs1 == ex_q.rd)) || (use_rs2 && (dec.rs2 == ex_q.rd)));
    assign stall    = !flush && (busy || load_use);

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d  = '0;
            cnt_d = 5'd0;
        end else if (busy) begin
            cnt_d = cnt_q - 5'd1;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d  = dec;
            cnt_d = is_div ? DIV_INIT : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= 5'd0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_alusrc     = ex_q.alusrc;
    assign ex_branch     = ex_q.branch;
    assign ex_jal        = ex_q.jal;
    assign ex_jalr       = ex_q.jalr;
    assign ex_auipc      = ex_q.auipc;
    assign ex_lui        = ex_q.lui;
    assign ex_muldiv     = ex_q.muldiv;
    assign ex_illegal    = ex_q.illegal;
    assign ex_resultsrc  = ex_q.resultsrc;
    assign ex_immtype    = ex_q.immtype;
    assign ex_alucontrol = ex_q.alucontrol;
    assign ex_funct3     = ex_q.funct3;
    assign ex_rd         = ex_q.rd;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: instance 0 is RV32I only, instance 1 has RV32M with DIV_LAT=4.
module tb_ctrl_decode_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        flush;

    logic [1:0] o_stall, o_valid, o_regwrite, o_memwrite, o_memread, o_alusrc, o_branch;
    logic [1:0] o_jal, o_jalr, o_auipc, o_lui, o_muldiv, o_illegal;
    logic [1:0][1:0] o_rsrc;
    logic [1:0][2:0] o_it, o_f3;
    logic [1:0][4:0] o_alu, o_rd, o_rs1, o_rs2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.M_EXT(0), .DIV_LAT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .flush(flush),
        .stall(o_stall[0]), .ex_valid(o_valid[0]), .ex_regwrite(o_regwrite[0]),
        .ex_memwrite(o_memwrite[0]), .ex_memread(o_memread[0]), .ex_alusrc(o_alusrc[0]),
        .ex_branch(o_branch[0]), .ex_jal(o_jal[0]), .ex_jalr(o_jalr[0]), .ex_auipc(o_auipc[0]),
        .ex_lui(o_lui[0]), .ex_muldiv(o_muldiv[0]), .ex_illegal(o_illegal[0]),
        .ex_resultsrc(o_rsrc[0]), .ex_immtype(o_it[0]), .ex_alucontrol(o_alu[0]),
        .ex_funct3(o_f3[0]), .ex_rd(o_rd[0]), .ex_rs1(o_rs1[0]), .ex_rs2(o_rs2[0])
    );

    ctrl_decode_pipe #(.M_EXT(1), .DIV_LAT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .flush(flush),
        .stall(o_stall[1]), .ex_valid(o_valid[1]), .ex_regwrite(o_regwrite[1]),
        .ex_memwrite(o_memwrite[1]), .ex_memread(o_memread[1]), .ex_alusrc(o_alusrc[1]),
        .ex_branch(o_branch[1]), .ex_jal(o_jal[1]), .ex_jalr(o_jalr[1]), .ex_auipc(o_auipc[1]),
        .ex_lui(o_lui[1]), .ex_muldiv(o_muldiv[1]), .ex_illegal(o_illegal[1]),
        .ex_resultsrc(o_rsrc[1]), .ex_immtype(o_it[1]), .ex_alucontrol(o_alu[1]),
        .ex_funct3(o_f3[1]), .ex_rd(o_rd[1]), .ex_rs1(o_rs1[1]), .ex_rs2(o_rs2[1])
    );

    // Flag order: valid regwrite memwrite memread alusrc branch jal jalr auipc lui muldiv illegal
    localparam logic [11:0] F_V = 12'h800, F_RW = 12'h400, F_MW = 12'h200, F_MR = 12'h100,
                            F_AS = 12'h080, F_BR = 12'h040, F_JAL = 12'h020, F_JALR = 12'h010,
                            F_AUI = 12'h008, F_LUI = 12'h004, F_MD = 12'h002, F_ILL = 12'h001;
    localparam logic [39:0] M_ALL = {40{1'b1}}, M_FLAGS = 40'hFFF << 28, M_RS = 40'h3 << 26,
                            M_IT = 40'h7 << 23, M_F3 = 40'h7 << 15, M_RD = 40'h1F << 10,
                            M_RS1 = 40'h1F << 5, M_RS2 = 40'h1F;

    localparam logic [31:0] I_ADD = 32'h002081B3, I_LW5 = 32'h0000A283, I_ADD6 = 32'h00728333,
                            I_LW0 = 32'h0000A003, I_ADD6X0 = 32'h00700333, I_DIV = 32'h02C5C533;

    function automatic logic [39:0] mk(input logic [11:0] fl, input logic [1:0] rs, input logic [2:0] it,
                                       input logic [4:0] alu, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {fl, rs, it, alu, f3, rd, rs1, rs2};
    endfunction

    function automatic logic [39:0] obs(input int d);
        return {o_valid[d], o_regwrite[d], o_memwrite[d], o_memread[d], o_alusrc[d], o_branch[d],
                o_jal[d], o_jalr[d], o_auipc[d], o_lui[d], o_muldiv[d], o_illegal[d],
                o_rsrc[d], o_it[d], o_alu[d], o_f3[d], o_rd[d], o_rs1[d], o_rs2[d]};
    endfunction

    logic [1:0]  q_who[$];
    logic [39:0] q_exp[$];
    logic [39:0] q_msk[$];

    task automatic step(input logic [31:0] i, input logic v, input logic f);
        if_id_inst  = i;
        if_id_valid = v;
        flush       = f;
        #1;
    endtask

    task automatic sc(input logic [1:0] who, input logic e, input string tag);
        for (int d = 0; d < 2; d++) begin
            if (who[d]) begin
                n_vec++;
                assert (o_stall[d] === e) else begin
                    n_err++;
                    $error("FAIL %s dut%0d stall got %b want %b", tag, d, o_stall[d], e);
                end
            end
        end
    endtask

    task automatic cmp(input int d, input logic [39:0] e, input logic [39:0] m, input string tag);
        logic [39:0] o;
        o = obs(d);
        n_vec++;
        assert ((o & m) === (e & m)) else begin
            n_err++;
            $error("FAIL %s dut%0d ex got %h want %h", tag, d, o & m, e & m);
        end
    endtask

    task automatic cmp_now(input logic [1:0] who, input logic [39:0] e, input logic [39:0] m, input string tag);
        for (int d = 0; d < 2; d++)
            if (who[d]) cmp(d, e, m, tag);
    endtask

    task automatic ex(input logic [1:0] who, input logic [39:0] e, input logic [39:0] m);
        q_who.push_back(who);
        q_exp.push_back(e);
        q_msk.push_back(m);
    endtask

    task automatic tick(input string tag);
        logic [1:0]  w;
        logic [39:0] e, m;
        @(posedge clk);
        #1;
        while (q_who.size() > 0) begin
            w = q_who.pop_front();
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            cmp_now(w, e, m, tag);
        end
    endtask

    task automatic chk_known(input string tag);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            assert (!$isunknown({obs(d), o_stall[d]})) else begin
                n_err++;
                $error("FAIL %s dut%0d outputs got %h want no X", tag, d, obs(d));
            end
        end
    endtask

    logic [39:0] E_ADD, E_LW5, E_ADD6, E_LW0, E_ADD6X0, E_DIV, E_ILL;
    logic [31:0] t_inst[9];
    logic [39:0] t_exp[9];
    logic [39:0] t_msk[9];

    initial begin
        E_ADD    = mk(F_V | F_RW, 2'b00, 3'b000, 5'b00000, 3'b000, 5'd3, 5'd1, 5'd2);
        E_LW5    = mk(F_V | F_RW | F_MR | F_AS, 2'b01, 3'b000, 5'b00000, 3'b010, 5'd5, 5'd1, 5'd0);
        E_ADD6   = mk(F_V | F_RW, 2'b00, 3'b000, 5'b00000, 3'b000, 5'd6, 5'd5, 5'd7);
        E_LW0    = mk(F_V | F_RW | F_MR | F_AS, 2'b01, 3'b000, 5'b00000, 3'b010, 5'd0, 5'd1, 5'd0);
        E_ADD6X0 = mk(F_V | F_RW, 2'b00, 3'b000, 5'b00000, 3'b000, 5'd6, 5'd0, 5'd7);
        E_DIV    = mk(F_V | F_RW | F_MD, 2'b00, 3'b000, 5'b01100, 3'b100, 5'd10, 5'd11, 5'd12);
        E_ILL    = mk(F_V | F_ILL, 2'b00, 3'b000, 5'b00000, 3'b000, 5'd0, 5'd0, 5'd0);

        t_inst[0] = 32'h0020A223; t_exp[0] = mk(F_V | F_MW | F_AS, 2'b00, 3'b001, 5'b00000, 3'b010, 5'd0, 5'd1, 5'd2);
        t_msk[0]  = ~(M_RD | M_RS);
        t_inst[1] = 32'h00208463; t_exp[1] = mk(F_V | F_BR, 2'b00, 3'b010, 5'b10000, 3'b000, 5'd0, 5'd1, 5'd2);
        t_msk[1]  = ~(M_RD | M_RS);
        t_inst[2] = 32'h010000EF; t_exp[2] = mk(F_V | F_RW | F_JAL, 2'b10, 3'b100, 5'b00000, 3'b000, 5'd1, 5'd0, 5'd0);
        t_msk[2]  = ~(M_F3 | M_RS1 | M_RS2);
        t_inst[3] = 32'h000280E7; t_exp[3] = mk(F_V | F_RW | F_AS | F_JALR, 2'b10, 3'b000, 5'b00000, 3'b000, 5'd1, 5'd5, 5'd0);
        t_msk[3]  = ~M_RS2;
        t_inst[4] = 32'h123453B7; t_exp[4] = mk(F_V | F_RW | F_AS | F_LUI, 2'b00, 3'b011, 5'b00000, 3'b000, 5'd7, 5'd0, 5'd0);
        t_msk[4]  = ~(M_F3 | M_RS1 | M_RS2);
        t_inst[5] = 32'h00001417; t_exp[5] = mk(F_V | F_RW | F_AS | F_AUI, 2'b00, 3'b011, 5'b00000, 3'b000, 5'd8, 5'd0, 5'd0);
        t_msk[5]  = ~(M_F3 | M_RS1 | M_RS2);
        t_inst[6] = 32'h40208233; t_exp[6] = mk(F_V | F_RW, 2'b00, 3'b000, 5'b10000, 3'b000, 5'd4, 5'd1, 5'd2);
        t_msk[6]  = ~M_IT;
        t_inst[7] = 32'h4030D493; t_exp[7] = mk(F_V | F_RW | F_AS, 2'b00, 3'b000, 5'b00110, 3'b101, 5'd9, 5'd1, 5'd0);
        t_msk[7]  = ~M_RS2;
        t_inst[8] = 32'h0020B533; t_exp[8] = mk(F_V | F_RW, 2'b00, 3'b000, 5'b11000, 3'b011, 5'd10, 5'd1, 5'd2);
        t_msk[8]  = ~M_IT;

        rst_n = 1'b0;
        step(32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cmp_now(2'b11, 40'h0, M_ALL, "reset_bubble");
        sc(2'b11, 1'b0, "reset_stall");
        rst_n = 1'b1;

        step(I_ADD, 1'b1, 1'b0);      sc(2'b11, 1'b0, "add_stall");  ex(2'b11, E_ADD, ~M_IT);  tick("add");
        step(32'h0, 1'b0, 1'b0);                                     ex(2'b11, 40'h0, M_ALL);  tick("invalid_bubble");

        step(I_LW5, 1'b1, 1'b0);      sc(2'b11, 1'b0, "lw_stall");   ex(2'b11, E_LW5, M_ALL);  tick("lw");
        step(I_ADD6, 1'b1, 1'b0);     sc(2'b11, 1'b1, "lu_stall");   ex(2'b11, 40'h0, M_ALL);  tick("lu_bubble");
        step(I_ADD6, 1'b1, 1'b0);     sc(2'b11, 1'b0, "lu_release"); ex(2'b11, E_ADD6, ~M_IT); tick("lu_add");
        step(I_LW0, 1'b1, 1'b0);                                     ex(2'b11, E_LW0, M_ALL);  tick("lw_x0");
        step(I_ADD6X0, 1'b1, 1'b0);   sc(2'b11, 1'b0, "x0_nostall"); ex(2'b11, E_ADD6X0, ~M_IT); tick("x0_add");

        for (int k = 0; k < 9; k++) begin
            step(t_inst[k], 1'b1, 1'b0);
            sc(2'b11, 1'b0, "decode_stall");
            ex(2'b11, t_exp[k], t_msk[k]);
            tick("decode");
        end

        step(32'h02309493, 1'b1, 1'b0); ex(2'b11, E_ILL, M_FLAGS); tick("slli_bad_f7");
        step(32'hFFFFFFFF, 1'b1, 1'b0); ex(2'b11, E_ILL, M_FLAGS); tick("all_ones");
        chk_known("all_ones_known");
        step(32'h0000007F, 1'b1, 1'b0); ex(2'b11, E_ILL, M_FLAGS); tick("opcode_7f");
        chk_known("opcode_7f_known");

        step(I_DIV, 1'b1, 1'b0);
        sc(2'b11, 1'b0, "div_issue");
        ex(2'b10, E_DIV, ~M_IT); ex(2'b01, E_ILL, M_FLAGS);
        tick("div_capture");
        for (int k = 0; k < 3; k++) begin
            step(I_ADD, 1'b1, 1'b0);
            sc(2'b10, 1'b1, "div_busy_stall");
            sc(2'b01, 1'b0, "noM_nostall");
            ex(2'b10, E_DIV, ~M_IT); ex(2'b01, E_ADD, ~M_IT);
            tick("div_hold");
        end
        step(I_ADD, 1'b1, 1'b0);  sc(2'b11, 1'b0, "div_done_stall"); ex(2'b11, E_ADD, ~M_IT); tick("div_done");

        step(I_LW5, 1'b1, 1'b0);  ex(2'b11, E_LW5, M_ALL); tick("lw_pre_flush");
        step(I_ADD6, 1'b1, 1'b1); sc(2'b11, 1'b0, "flush_lu_stall"); ex(2'b11, 40'h0, M_ALL); tick("flush_lu");
        step(I_ADD6, 1'b1, 1'b0); sc(2'b11, 1'b0, "after_flush_lu"); ex(2'b11, E_ADD6, ~M_IT); tick("after_flush_lu");

        step(I_DIV, 1'b1, 1'b0);  ex(2'b10, E_DIV, ~M_IT); ex(2'b01, E_ILL, M_FLAGS); tick("div2_capture");
        step(I_ADD, 1'b1, 1'b0);  sc(2'b10, 1'b1, "div2_busy"); ex(2'b10, E_DIV, ~M_IT); tick("div2_hold");
        step(I_ADD, 1'b1, 1'b1);  sc(2'b11, 1'b0, "flush_busy_stall"); ex(2'b11, 40'h0, M_ALL); tick("flush_busy");
        step(I_ADD, 1'b1, 1'b0);  sc(2'b11, 1'b0, "cnt_cleared"); ex(2'b11, E_ADD, ~M_IT); tick("after_flush_busy");

        step(I_DIV, 1'b1, 1'b0);  ex(2'b10, E_DIV, ~M_IT); tick("div3_capture");
        step(I_ADD, 1'b1, 1'b0);  sc(2'b10, 1'b1, "div3_busy"); ex(2'b10, E_DIV, ~M_IT); tick("div3_hold");
        rst_n = 1'b0;
        #1;
        cmp_now(2'b11, 40'h0, M_ALL, "rst_async_bubble");
        sc(2'b11, 1'b0, "rst_async_stall");
        #1;
        rst_n = 1'b1;
        step(I_ADD, 1'b1, 1'b0);  sc(2'b11, 1'b0, "post_rst_stall"); ex(2'b11, E_ADD, ~M_IT); tick("post_rst_add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ctrl_decode_pipe.md
CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 Parameter M_EXT, default 0, meaning: 1 enables RV32M (MUL/DIV/REM) decode; 0 treats funct7=0000001 R-type as illegal.
REQ-002 Parameter DIV_LAT, default 4 (range 2..32), meaning: total EX cycles a DIV/DIVU/REM/REMU occupies.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 if_id_inst  in  32  instruction in ID.
REQ-007 if_id_valid  in  1  if_id_inst holds a real instruction.
REQ-008 flush  in  1  EX redirect (taken branch/JAL/JALR); kills ID contents.
REQ-009 stall  out  1  combinational; holds PC and IF/ID register.
REQ-010 ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_alusrc, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_lui, ex_muldiv, ex_illegal  out  1 each  registered ID/EX control bundle.
REQ-011 ex_resultsrc  out  2; ex_immtype  out  3; ex_alucontrol  out  5; ex_funct3  out  3; ex_rd, ex_rs1, ex_rs2  out  5 each  registered ID/EX fields.

Function
REQ-012 Decode SHALL keep existing encodings: RV32I opcodes, immtype I=000 S=001 B=010 U=011 J=100, resultsrc ALU=00 MEM=01 PC+4=10; JALR resultsrc=10.
REQ-013 ALU codes: ADD 00000, SUB 10000, AND 00001, OR 00010, XOR 00011, SLL 00100, SRL 00101, SRA 00110, SLT 10111, SLTU 11000; branches SUB; load/store/JALR/LUI/AUIPC/JAL ADD.
REQ-014 M_EXT=1: MUL 01000, MULH 01001, MULHSU 01010, MULHU 01011, DIV 01100, DIVU 01101, REM 01110, REMU 01111; ex_muldiv=1.
REQ-015 All decode outputs SHALL be deterministic (no X) for every input.
REQ-016 Illegal (unknown opcode, bad funct7/funct3, SLLI/SRLI/SRAI bad funct7): ex_valid=1, ex_illegal=1, all write/branch/jump/memory enables 0.
REQ-017 Source use: rs1 used by R, I-arith, load, JALR, S, B; rs2 used by R, S, B only.
REQ-018 Load-use hazard = if_id_valid & ex_valid & ex_memread & ex_rd!=0 & ex_rd matches a used source.
REQ-019 Div-busy counter: loads DIV_LAT-1 on the edge a DIV/DIVU/REM/REMU is captured into ID/EX; decrements by 1 each cycle while nonzero; busy = counter!=0.
REQ-020 Per-edge priority: flush > busy > load-use > capture.
REQ-021 flush: ID/EX SHALL load a bubble, counter SHALL clear, stall=0.
REQ-022 busy (no flush): stall=1, ID/EX SHALL hold unchanged.
REQ-023 load-use (no flush, not busy): stall=1, ID/EX SHALL load a bubble; next cycle proceeds normally.
REQ-024 Otherwise: stall=0; ID/EX SHALL capture decode of if_id_inst, ex_valid=if_id_valid; if_id_valid=0 yields a bubble.
REQ-025 Bubble = ex_valid=0 and every other output 0.
REQ-026 Decode-to-EX latency SHALL be exactly 1 cycle when unstalled.

Reset
REQ-027 rst_n=0 SHALL immediately force ID/EX to bubble and counter to 0, including mid-divide; stall=0 during reset.
REQ-028 First edge after rst_n release SHALL capture normally.

Verification
REQ-029 0x002081B3 (add x3,x1,x2) valid -> next cycle ex_valid=1, ex_regwrite=1, ex_alucontrol=00000, ex_rd=3, stall=0.
REQ-030 0x0000A283 (lw x5,0(x1)) then 0x00728333 (add x6,x5,x7) -> stall=1 one cycle, one bubble, then add in EX; repeat with rd=x0 -> no stall.
REQ-031 M_EXT=1, DIV_LAT=4, 0x02C5C533 (div x10,x11,x12) -> ex_alucontrol=01100, stall=1 for 3 cycles, ID/EX held; M_EXT=0 -> ex_illegal=1, no stall.
REQ-032 flush asserted during load-use and during busy -> bubble captured, stall=0, counter cleared.
REQ-033 0xFFFFFFFF and opcode 0x7F -> ex_illegal=1, enables 0, no X on any output.
REQ-034 rst_n low mid-divide (counter=2) -> outputs bubble asynchronously, stall=0; after release add captured next edge.
